// File: rtl/pid_multichannel_wb.sv
// pid_multichannel_wb: NCH-channel PID sharing one multiplier behind a Wishbone classic slave.
// Define PID_SAT_EN for saturating sigma/un with anti-windup; default build wraps.
module pid_multichannel_wb #(
  parameter int WB_DW = 32,
  parameter int ADR_W = 16,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [ADR_W-1:0]     i_wb_adr,
  input  logic [WB_DW-1:0]     i_wb_data,
  output logic                 o_wb_ack,
  output logic [WB_DW-1:0]     o_wb_data,
  output logic [NCH*ACC_W-1:0] o_un,
  output logic [NCH-1:0]       o_valid
);
  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MI, S_MP, S_MD, S_ACC, S_OUT} state_t;
  localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t r_state;
  logic [CH_W-1:0] r_ch, r_last;
  logic [NCH-1:0] r_pend;
  logic signed [DW-1:0] r_kp [NCH], r_ki [NCH], r_kd [NCH], r_sp [NCH], r_pv [NCH];
  logic signed [DW-1:0] r_kpd [NCH], r_e0 [NCH], r_e1 [NCH];
  logic signed [ACC_W-1:0] r_sig [NCH], r_un [NCH];
  logic [4:0] r_of [NCH];
  logic signed [ACC_W-1:0] r_pi, r_pp, r_pd;
  logic [CH_W-1:0] w_ch, w_pick, w_k;
  logic [3:0] w_reg;
  logic w_hi_ok, w_busy, w_stall, w_acc, w_wr, w_unused;
  logic [WB_DW-1:0] w_rd;
  logic signed [DW-1:0] w_wd, w_ma, w_mb;
  logic signed [DW:0] w_e, w_kpd;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACC_W:0] w_sig_f, w_t, w_u;
  logic signed [ACC_W-1:0] w_sig_n, w_un;
  logic w_ov_s, w_ov_t, w_ov_u, w_un_sat;
  assign w_unused = ^i_wb_adr[1:0];
  assign w_ch     = i_wb_adr[5+CH_W:6];
  assign w_reg    = i_wb_adr[5:2];
  assign w_hi_ok  = i_wb_adr[ADR_W-1:6+CH_W] == '0;
  assign w_busy   = r_state != S_IDLE;
  // only the channel in flight is protected; its operands are free again once OUT is reached
  assign w_stall  = i_wb_we && w_hi_ok && (w_reg <= 4'd4 || w_reg == 4'd11) && w_busy &&
                    w_ch == r_ch && r_state != S_OUT;
  assign w_acc    = i_wb_cyc && i_wb_stb && !o_wb_ack && !w_stall;
  assign w_wr     = w_acc && i_wb_we && w_hi_ok;
  assign w_wd     = i_wb_data[DW-1:0];
  assign w_kpd    = w_reg == 4'd0 ? (DW+1)'(w_wd) + (DW+1)'(r_kd[w_ch])
                                  : (DW+1)'(r_kp[w_ch]) + (DW+1)'(w_wd);
  assign w_e      = (DW+1)'(r_sp[r_ch]) - (DW+1)'(r_pv[r_ch]);
  assign w_ma     = r_state == S_MI ? r_ki[r_ch] : r_state == S_MP ? r_kpd[r_ch] : r_kd[r_ch];
  assign w_mb     = r_state == S_MD ? r_e1[r_ch] : r_e0[r_ch];
  assign w_prod   = (2*DW)'(w_ma) * (2*DW)'(w_mb);
  assign w_sig_f  = (ACC_W+1)'(r_sig[r_ch]) + (ACC_W+1)'(r_pi);
  assign w_ov_s   = w_sig_f[ACC_W] ^ w_sig_f[ACC_W-1];
  assign w_t      = (ACC_W+1)'(r_pp) + (ACC_W+1)'(w_sig_n);
  assign w_ov_t   = w_t[ACC_W] ^ w_t[ACC_W-1];
  assign w_u      = (ACC_W+1)'($signed(w_t[ACC_W-1:0])) - (ACC_W+1)'(r_pd);
  assign w_ov_u   = w_u[ACC_W] ^ w_u[ACC_W-1];
`ifdef PID_SAT_EN
  logic signed [ACC_W+1:0] w_x;
  assign w_sig_n  = w_ov_s ? (w_sig_f[ACC_W] ? MIN : MAX) : w_sig_f[ACC_W-1:0];
  assign w_x      = (ACC_W+2)'(r_pp) + (ACC_W+2)'(w_sig_n) - (ACC_W+2)'(r_pd);
  assign w_un_sat = !(w_x[ACC_W+1:ACC_W-1] == '0 || w_x[ACC_W+1:ACC_W-1] == '1);
  assign w_un     = w_un_sat ? (w_x[ACC_W+1] ? MIN : MAX) : w_x[ACC_W-1:0];
`else
  assign w_sig_n  = w_sig_f[ACC_W-1:0];
  assign w_un_sat = 1'b0;
  assign w_un     = w_u[ACC_W-1:0];
`endif
  for (genvar k = 0; k < NCH; k++) begin : g_un
    assign o_un[k*ACC_W +: ACC_W] = r_un[k];
  end
  // round-robin: descending scan so the lowest offset from last_ch+1 wins
  always_comb begin
    w_pick = r_ch;
    w_k = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      w_k = CH_W'((int'(r_last) + 1 + i) % NCH);
      if (r_pend[w_k]) w_pick = w_k;
    end
  end
  always_comb begin
    w_rd = '0;
    if (w_hi_ok)
      case (w_reg)
        4'd0:    w_rd = WB_DW'(r_kp[w_ch]);
        4'd1:    w_rd = WB_DW'(r_ki[w_ch]);
        4'd2:    w_rd = WB_DW'(r_kd[w_ch]);
        4'd3:    w_rd = WB_DW'(r_sp[w_ch]);
        4'd4:    w_rd = WB_DW'(r_pv[w_ch]);
        4'd5:    w_rd = WB_DW'(r_kpd[w_ch]);
        4'd6:    w_rd = WB_DW'(r_e0[w_ch]);
        4'd7:    w_rd = WB_DW'(r_e1[w_ch]);
        4'd8:    w_rd = WB_DW'(r_un[w_ch]);
        4'd9:    w_rd = WB_DW'(r_sig[w_ch]);
        4'd10:   w_rd = WB_DW'(r_of[w_ch]);
        4'd12:   w_rd = WB_DW'({r_ch, w_busy, r_pend});
        default: w_rd = '0;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_last    <= '0;
      r_pend    <= '0;
      r_pi      <= '0;
      r_pp      <= '0;
      r_pd      <= '0;
      o_valid   <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_kp[i]  <= '0;
        r_ki[i]  <= '0;
        r_kd[i]  <= '0;
        r_sp[i]  <= '0;
        r_pv[i]  <= '0;
        r_kpd[i] <= '0;
        r_e0[i]  <= '0;
        r_e1[i]  <= '0;
        r_sig[i] <= '0;
        r_un[i]  <= '0;
        r_of[i]  <= '0;
      end
    end else begin
      o_valid   <= '0;
      o_wb_ack  <= w_acc;
      o_wb_data <= w_acc && !i_wb_we ? w_rd : '0;
      case (r_state)
        S_IDLE: if (|r_pend) begin
          r_ch           <= w_pick;
          r_last         <= w_pick;
          r_pend[w_pick] <= 1'b0;
          r_state        <= S_ERR;
        end
        S_ERR: begin
          r_e1[r_ch]      <= r_e0[r_ch];
          r_e0[r_ch]      <= w_e[DW-1:0];
          r_of[r_ch][2:1] <= {r_of[r_ch][1], w_e[DW] ^ w_e[DW-1]};
          r_state         <= S_MI;
        end
        S_MI: begin
          r_pi    <= ACC_W'(w_prod);
          r_state <= S_MP;
        end
        S_MP: begin
          r_pp    <= ACC_W'(w_prod);
          r_state <= S_MD;
        end
        S_MD: begin
          r_pd    <= ACC_W'(w_prod);
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_sig[r_ch]     <= w_un_sat ? r_sig[r_ch] : w_sig_n;
          r_un[r_ch]      <= w_un;
          r_of[r_ch][4:3] <= {r_of[r_ch][4] | w_ov_s, r_of[r_ch][4] | w_ov_s | w_ov_t | w_ov_u};
          o_valid[r_ch]   <= 1'b1;
          r_state         <= S_OUT;
        end
        default: r_state <= S_IDLE;
      endcase
      // bus writes come last so a pv write re-arms pend over the scheduler's clear
      if (w_wr)
        case (w_reg)
          4'd0: begin
            r_kp[w_ch]    <= w_wd;
            r_kpd[w_ch]   <= w_kpd[DW-1:0];
            r_of[w_ch][0] <= w_kpd[DW] ^ w_kpd[DW-1];
          end
          4'd1: r_ki[w_ch] <= w_wd;
          4'd2: begin
            r_kd[w_ch]    <= w_wd;
            r_kpd[w_ch]   <= w_kpd[DW-1:0];
            r_of[w_ch][0] <= w_kpd[DW] ^ w_kpd[DW-1];
          end
          4'd3: r_sp[w_ch] <= w_wd;
          4'd4: begin
            r_pv[w_ch]   <= w_wd;
            r_pend[w_ch] <= 1'b1;
          end
          4'd11: if (i_wb_data == '0) begin
            r_e0[w_ch]  <= '0;
            r_e1[w_ch]  <= '0;
            r_sig[w_ch] <= '0;
            r_un[w_ch]  <= '0;
            r_of[w_ch]  <= '0;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_pid_multichannel_wb.sv
// tb_pid_multichannel_wb: scoreboard bench for pid_multichannel_wb with directed PID vectors.
module tb_pid_multichannel_wb;
  logic clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] wdat = '0, rdat;
  logic ack;
  logic [127:0] un;
  logic [3:0] vld;
  int n_cmp = 0, n_fail = 0, cyc_cnt = 0, t_ack = 0;
  logic [31:0] rd_q[$];
  string rd_nm[$];
  int un_ch_q[$];
  logic [31:0] un_q[$];

  pid_multichannel_wb dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_data(wdat), .o_wb_ack(ack), .o_wb_data(rdat),
    .o_un(un), .o_valid(vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] a(input int ch, input int rg);
    return 16'(ch * 64 + rg * 4);
  endfunction

  // monitor: pops the scoreboard whenever the DUT acks a read or pulses o_valid
  always @(negedge clk) if (rst_n) begin
    if (ack && !we) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL spurious read ack: got data %0h want no ack", rdat);
      end else chk(rd_nm.pop_front(), rdat, rd_q.pop_front());
    end
    for (int i = 0; i < 4; i++) if (vld[i]) begin
      if (un_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL spurious o_valid[%0d]: got 1 want 0", i);
      end else begin
        chk("valid ch", i, un_ch_q.pop_front());
        chk($sformatf("un ch%0d", i), un[i*32 +: 32], un_q.pop_front());
      end
    end
  end

  task automatic wb(input logic w, input logic [15:0] ad, input logic [31:0] d, output int n);
    cyc = 1; stb = 1; we = w; adr = ad; wdat = d; n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 100);
    if (!ack) begin
      n_cmp++; n_fail++;
      $display("FAIL ack timeout adr %h: got no ack want ack", ad);
    end
    t_ack = cyc_cnt;
    @(negedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] ad, input logic [31:0] d);
    int n;
    wb(1'b1, ad, d, n);
  endtask

  task automatic rd(input logic [15:0] ad, input logic [31:0] exp, input string nm);
    int n;
    rd_q.push_back(exp);
    rd_nm.push_back(nm);
    wb(1'b0, ad, '0, n);
    chk({nm, " ack lat"}, n, 1);
  endtask

  task automatic expect_un(input int ch, input logic [31:0] v);
    un_ch_q.push_back(ch);
    un_q.push_back(v);
  endtask

  task automatic drain();
    int k = 0;
    while (un_q.size() != 0 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (un_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain timeout: got %0d pending want 0", un_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ack", ack, 0);
    chk("rst valid", vld, 0);
    chk("rst un", un, 0);
    chk("rst rdat", rdat, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 16; r++) rd(a(c, r), 0, $sformatf("rst c%0d r%0d", c, r));
    chk("idle valid", vld, 0);
    // basic PID on ch1
    wr(a(1, 0), 2); wr(a(1, 1), 1); wr(a(1, 2), 1); wr(a(1, 3), 100);
    rd(a(1, 5), 3, "kpd ch1");
    expect_un(1, 240);
    wr(a(1, 4), 40);
    k = 0;
    while (!vld[1] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("pv ack to valid", cyc_cnt - t_ack, 6);
    drain();
    rd(a(1, 6), 60, "e0 ch1");
    rd(a(1, 7), 0, "e1 ch1");
    rd(a(1, 9), 60, "sigma ch1");
    rd(a(1, 8), 240, "un ch1");
    rd(a(1, 10), 0, "of ch1");
    rd(a(0, 12), 32'h20, "pend/busy after ch1");
    expect_un(1, 240);
    wr(a(1, 4), 40);
    drain();
    rd(a(1, 9), 120, "sigma ch1 s2");
    rd(a(1, 7), 60, "e1 ch1 s2");
    // four channels queued back to back
    wr(a(0, 0), 1); wr(a(0, 3), 10);
    wr(a(2, 0), 3); wr(a(2, 1), 2); wr(a(2, 2), 0); wr(a(2, 3), 32'hFFFF_FFFB);
    wr(a(3, 0), 0); wr(a(3, 2), 4); wr(a(3, 3), 0);
    expect_un(0, 7); expect_un(1, 100); expect_un(2, 32'hFFFF_FFCE); expect_un(3, 28);
    wr(a(0, 4), 3); wr(a(1, 4), 90); wr(a(2, 4), 5); wr(a(3, 4), 32'hFFFF_FFF9);
    drain();
    rd(a(0, 8), 7, "un ch0 rr");
    rd(a(1, 8), 100, "un ch1 rr");
    rd(a(2, 8), 32'hFFFF_FFCE, "un ch2 rr");
    rd(a(3, 8), 28, "un ch3 rr");
    rd(a(1, 9), 130, "sigma ch1 rr");
    rd(a(2, 9), 32'hFFFF_FFEC, "sigma ch2 rr");
    rd(a(2, 6), 32'hFFFF_FFF6, "e0 ch2 rr");
    rd(a(3, 5), 4, "kpd ch3");
    rd(a(0, 12), 32'h60, "pend/busy after rr");
    // kp write to the busy channel must wait for OUT
    expect_un(2, 32'hFFFF_FFBA);
    wr(a(2, 4), 5);
    wb(1'b1, a(2, 0), 1, n);
    chk("stalled kp ack lat", n, 6);
    drain();
    rd(a(2, 5), 1, "kpd ch2 new");
    expect_un(2, 32'hFFFF_FFBA);
    wr(a(2, 4), 5);
    drain();
    rd(a(2, 9), 32'hFFFF_FFC4, "sigma ch2 s3");
    // overflow path on ch0
    wr(a(0, 11), 0);
    rd(a(0, 9), 0, "sigma ch0 cleared");
    rd(a(0, 6), 0, "e0 ch0 cleared");
    wr(a(0, 0), 0); wr(a(0, 1), 32'h8000); wr(a(0, 2), 0); wr(a(0, 3), 0);
    expect_un(0, 32'h4000_0000);
    wr(a(0, 4), 32'h8000);
    drain();
    rd(a(0, 10), 32'h02, "of ch0 s1");
    rd(a(0, 6), 32'hFFFF_8000, "e0 ch0 s1");
    rd(a(0, 9), 32'h4000_0000, "sigma ch0 s1");
`ifdef PID_SAT_EN
    expect_un(0, 32'h7FFF_FFFF);
    wr(a(0, 4), 32'h8000);
    drain();
    rd(a(0, 9), 32'h7FFF_FFFF, "sigma ch0 clamp");
`else
    expect_un(0, 32'h8000_0000);
    wr(a(0, 4), 32'h8000);
    drain();
    rd(a(0, 9), 32'h8000_0000, "sigma ch0 wrap");
`endif
    rd(a(0, 10), 32'h1E, "of ch0 s2");
    wr(a(0, 0), 32'h7FFF);
    wr(a(0, 2), 1);
    rd(a(0, 5), 32'hFFFF_8000, "kpd ch0 ovf");
    rd(a(0, 10), 32'h1F, "of ch0 kpd");
    // RS behaviour
    wr(a(1, 11), 5);
    rd(a(1, 9), 130, "sigma ch1 RS5");
    rd(a(1, 8), 100, "un ch1 RS5");
    wr(a(3, 11), 0);
    rd(a(3, 6), 0, "e0 ch3 RS0");
    rd(a(3, 7), 0, "e1 ch3 RS0");
    rd(a(3, 9), 0, "sigma ch3 RS0");
    rd(a(3, 8), 0, "un ch3 RS0");
    rd(a(3, 10), 0, "of ch3 RS0");
    rd(a(3, 2), 4, "kd ch3 kept");
    // out-of-range address bits and reserved registers
    wr(a(3, 2) | 16'h0100, 9);
    rd(a(3, 2), 4, "kd ch3 hi-adr wr");
    rd(a(3, 2) | 16'h0100, 0, "hi-adr rd");
    wr(a(1, 13), 7);
    rd(a(1, 13), 0, "reg13");
    chk("un_q empty", un_q.size(), 0);
    chk("rd_q empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
